ac_walk_ctrl: RTL

Sequencer for the Aho-Corasick table walk. For each 4-bit input character it reads the goto RAM, and on a miss walks the failure RAM until a goto hit or the root. Sits between the character source and the GOTO_RAM/FAILURE_RAM read ports. Emits the next state plus a one-cycle strobe that drives the REGISTER/MATCH enable, so the goto/failure lookups are serialized on single-ported, 1-cycle-latency RAMs.

---
 rtl/ac_walk_ctrl_pkg.sv | 27 ++
 rtl/ac_walk_ctrl_if.sv | 41 ++++
 rtl/ac_walk_ctrl_hop_guard.sv | 41 ++++
 rtl/ac_walk_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ac_walk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ac_walk_ctrl_pkg
// Shared constants and types for the Aho-Corasick table-walk controller:
// state/character/address widths, goto "no transition" marker, root state,
// RAM read latency and the walk FSM state encoding.
// ---------------------------------------------------------------------------
package ac_walk_ctrl_pkg;

    localparam int STATE_W = 8;
    localparam int CHAR_W  = 4;
    localparam int ADDR_W  = STATE_W + CHAR_W;

    localparam logic [STATE_W-1:0] FAIL_CODE = 8'hFF;
    localparam logic [STATE_W-1:0] ROOT      = 8'h00;

    // Cycles between a RAM read strobe and valid read data.
    localparam int RAM_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        G_RD,
        G_CHK,
        F_RD,
        F_CHK
    } ac_walk_st_t;

endpackage

// File: rtl/ac_walk_ctrl_if.sv
// ---------------------------------------------------------------------------
// ac_walk_ctrl_if
// Bundles the character handshake, goto/failure RAM read ports and the
// automaton state outputs of the walk controller.
//   master : the walk controller (consumes characters, issues RAM reads,
//            publishes state)
//   slave  : the environment (character source, RAMs, state consumer)
// ---------------------------------------------------------------------------
interface ac_walk_ctrl_if;
    import ac_walk_ctrl_pkg::*;

    logic                str_valid;
    logic                str_ready;
    logic [CHAR_W-1:0]   str_char;

    logic                goto_rd;
    logic [ADDR_W-1:0]   goto_addr;
    logic [STATE_W-1:0]  goto_data;

    logic                fail_rd;
    logic [ADDR_W-1:0]   fail_addr;
    logic [STATE_W-1:0]  fail_data;

    logic [STATE_W-1:0]  state;
    logic                state_valid;
    logic                busy;
    logic                err;

    modport master (
        input  str_valid, str_char, goto_data, fail_data,
        output str_ready, goto_rd, goto_addr, fail_rd, fail_addr,
               state, state_valid, busy, err
    );

    modport slave (
        output str_valid, str_char, goto_data, fail_data,
        input  str_ready, goto_rd, goto_addr, fail_rd, fail_addr,
               state, state_valid, busy, err
    );

endinterface

// File: rtl/ac_walk_ctrl_hop_guard.sv
// ---------------------------------------------------------------------------
// ac_hop_guard
// Saturating 8-bit count of failure hops taken for the current character.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear the count (new character or re-initialise)
//   i_inc          : one failure hop completed this cycle
//   o_limit_hit    : the count after this increment reaches MAX_HOPS
// ---------------------------------------------------------------------------
module ac_hop_guard #(
    parameter int unsigned MAX_HOPS = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_limit_hit
);

    // Limits above the counter range collapse onto the saturation value.
    localparam logic [7:0] LIMIT = (MAX_HOPS > 255) ? 8'hFF : 8'(MAX_HOPS);

    logic [7:0] r_hop_cnt;
    logic [7:0] w_hop_cnt_inc;

    assign w_hop_cnt_inc = (r_hop_cnt == 8'hFF) ? 8'hFF : r_hop_cnt + 8'd1;
    // Evaluated on the post-increment value so the hop that reaches the
    // limit is the one that terminates the walk.
    assign o_limit_hit   = i_inc && (w_hop_cnt_inc >= LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hop_cnt <= 8'd0;
        end else if (i_clr) begin
            r_hop_cnt <= 8'd0;
        end else if (i_inc) begin
            r_hop_cnt <= w_hop_cnt_inc;
        end
    end

endmodule

// File: rtl/ac_walk_ctrl.sv
// ---------------------------------------------------------------------------
// ac_walk_ctrl
// Aho-Corasick table-walk sequencer. Per accepted character it reads the goto
// RAM at {state, char}; on a miss away from the root it follows the failure
// RAM and retries until a goto hit, the root, or the hop guard fires.
// Ports:
//   i_clk        : clock, all logic on the rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_initialize : synchronous return to root, aborts any walk
//   bus          : character handshake, RAM read ports, state outputs
// ---------------------------------------------------------------------------
module ac_walk_ctrl
    import ac_walk_ctrl_pkg::*;
#(
    parameter int unsigned MAX_HOPS = 255
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_initialize,
    ac_walk_ctrl_if.master bus
);

    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    ac_walk_st_t          r_st, w_st_next;
    logic [STATE_W-1:0]   r_cur, w_cur_next;
    logic [CHAR_W-1:0]    r_char, w_char_next;
    logic [1:0]           r_lat, w_lat_next;
    logic                 r_goto_rd, w_goto_rd_next;
    logic [ADDR_W-1:0]    r_goto_addr, w_goto_addr_next;
    logic                 r_fail_rd, w_fail_rd_next;
    logic [ADDR_W-1:0]    r_fail_addr, w_fail_addr_next;
    logic                 r_state_valid, w_state_valid_next;
    logic                 r_err, w_err_next;
    logic                 w_hop_clr, w_hop_inc, w_hop_limit;

    ac_hop_guard #(.MAX_HOPS(MAX_HOPS)) u_hop_guard (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (w_hop_clr),
        .i_inc       (w_hop_inc),
        .o_limit_hit (w_hop_limit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st          <= IDLE;
            r_cur         <= ROOT;
            r_char        <= '0;
            r_lat         <= '0;
            r_goto_rd     <= 1'b0;
            r_goto_addr   <= '0;
            r_fail_rd     <= 1'b0;
            r_fail_addr   <= '0;
            r_state_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_st          <= w_st_next;
            r_cur         <= w_cur_next;
            r_char        <= w_char_next;
            r_lat         <= w_lat_next;
            r_goto_rd     <= w_goto_rd_next;
            r_goto_addr   <= w_goto_addr_next;
            r_fail_rd     <= w_fail_rd_next;
            r_fail_addr   <= w_fail_addr_next;
            r_state_valid <= w_state_valid_next;
            r_err         <= w_err_next;
        end
    end

    always_comb begin
        w_st_next          = r_st;
        w_cur_next         = r_cur;
        w_char_next        = r_char;
        w_lat_next         = '0;
        w_state_valid_next = 1'b0;
        w_err_next         = 1'b0;
        w_hop_clr          = 1'b0;
        w_hop_inc          = 1'b0;

        if (i_initialize) begin
            w_st_next  = IDLE;
            w_cur_next = ROOT;
            w_hop_clr  = 1'b1;
        end else begin
            case (r_st)
                IDLE: begin
                    // str_ready is exactly "IDLE and not initialising".
                    if (bus.str_valid) begin
                        w_char_next = bus.str_char;
                        w_hop_clr   = 1'b1;
                        w_st_next   = G_RD;
                    end
                end
                G_RD: begin
                    // Hold in the read stage until RAM data is due.
                    if (r_lat == LAT_LAST) w_st_next  = G_CHK;
                    else                   w_lat_next = r_lat + 2'd1;
                end
                G_CHK: begin
                    if (bus.goto_data != FAIL_CODE) begin
                        w_cur_next         = bus.goto_data;
                        w_state_valid_next = 1'b1;
                        w_st_next          = IDLE;
                    end else if (r_cur == ROOT) begin
                        // Root self-loop: no failure lookup needed.
                        w_cur_next         = ROOT;
                        w_state_valid_next = 1'b1;
                        w_st_next          = IDLE;
                    end else begin
                        w_st_next = F_RD;
                    end
                end
                F_RD: begin
                    if (r_lat == LAT_LAST) w_st_next  = F_CHK;
                    else                   w_lat_next = r_lat + 2'd1;
                end
                F_CHK: begin
                    w_hop_inc = 1'b1;
                    if (w_hop_limit) begin
                        w_cur_next         = ROOT;
                        w_state_valid_next = 1'b1;
                        w_err_next         = 1'b1;
                        w_st_next          = IDLE;
                    end else begin
                        w_cur_next = (bus.fail_data == FAIL_CODE) ? ROOT : bus.fail_data;
                        w_st_next  = G_RD;
                    end
                end
                default: w_st_next = IDLE;
            endcase
        end

        // Strobes fire only on entry to a read stage, so each is a single
        // pulse; addresses use the post-transition state so a retry after a
        // failure hop reads the goto RAM for the new state.
        w_goto_rd_next   = (w_st_next == G_RD) && (r_st != G_RD);
        w_fail_rd_next   = (w_st_next == F_RD) && (r_st != F_RD);
        w_goto_addr_next = w_goto_rd_next ? {w_cur_next, w_char_next} : r_goto_addr;
        w_fail_addr_next = w_fail_rd_next ? {{(ADDR_W-STATE_W){1'b0}}, w_cur_next}
                                          : r_fail_addr;
    end

    assign bus.str_ready   = (r_st == IDLE) && !i_initialize;
    assign bus.goto_rd     = r_goto_rd;
    assign bus.goto_addr   = r_goto_addr;
    assign bus.fail_rd     = r_fail_rd;
    assign bus.fail_addr   = r_fail_addr;
    assign bus.state       = r_cur;
    assign bus.state_valid = r_state_valid;
    assign bus.busy        = (r_st != IDLE);
    assign bus.err         = r_err;

endmodule
